// File: rtl/generation_engine_pkg.sv
// Shared definitions for the rectangle generation engine and the addressing engine:
// FSM encodings, framebuffer geometry defaults and colour pattern helpers.
package generation_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_e;

    localparam int FRAME_WIDTH_PX      = 640;
    localparam int PIXELS_PER_GROUP    = 8;
    localparam int DEFAULT_GROUP_BYTES = 3;
    localparam int DEFAULT_ROW_STRIDE  = (FRAME_WIDTH_PX / PIXELS_PER_GROUP) * DEFAULT_GROUP_BYTES;

    // Eight 3-bit pixels of the same colour packed into one 24-bit group.
    function automatic logic [23:0] pattern_word(input logic [2:0] color);
        return {8{color}};
    endfunction

    function automatic logic [7:0] pattern_byte(input logic [2:0] color, input logic [1:0] byte_idx);
        logic [23:0] word;
        logic [7:0]  result;
        word = pattern_word(color);
        case (byte_idx)
            2'd0:    result = word[23:16];
            2'd1:    result = word[15:8];
            2'd2:    result = word[7:0];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/gen_pattern_expand.sv
// Combinational colour-to-byte expansion for one byte of an 8-pixel group.
module gen_pattern_expand
    import generation_engine_pkg::*;
(
    input  logic [2:0] color,
    input  logic [1:0] byte_idx,
    output logic [7:0] wdata
);

    // Select the requested byte of the replicated colour pattern.
    always_comb begin
        wdata = 8'h00;
        wdata = pattern_byte(color, byte_idx);
    end

endmodule

// File: rtl/generation_engine.sv
// Rectangle fill sequencer: writes a solid-colour rectangle into the framebuffer row by row.
// Optional build macro GEN_WR_COUNT_EN adds the gen_wr_count accepted-write counter output.
module generation_engine
    import generation_engine_pkg::*;
#(
    parameter int ROW_STRIDE  = DEFAULT_ROW_STRIDE,
    parameter int GROUP_BYTES = DEFAULT_GROUP_BYTES
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        gen_start_strobe,
    input  logic [15:0] init_addr,
    input  logic [15:0] cmd_data_width,
    input  logic [15:0] cmd_data_height,
    input  logic [2:0]  cmd_data_color,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        gen_busy,
`ifdef GEN_WR_COUNT_EN
    output logic [31:0] gen_wr_count,
`endif
    output logic        gen_done_strobe
);

    localparam logic [15:0] STRIDE_STEP   = 16'(ROW_STRIDE);
    localparam logic [1:0]  LAST_BYTE_IDX = 2'(GROUP_BYTES - 1);

    gen_state_e  state_r;
    gen_state_e  state_nxt_s;
    logic        strobe_d_r;
    logic [15:0] width_r;
    logic [15:0] height_r;
    logic [2:0]  color_r;
    logic [15:0] row_base_r;
    logic [15:0] grp_r;
    logic [15:0] row_r;
    logic [1:0]  byte_idx_r;

    logic        start_s;
    logic        accept_s;
    logic        last_byte_s;
    logic        last_grp_s;
    logic        last_row_s;
    logic [15:0] base_nxt_s;
    logic [15:0] grp_nxt_s;
    logic [15:0] row_nxt_s;
    logic [15:0] addr_nxt_s;
    logic [1:0]  byte_nxt_s;
    logic [7:0]  wdata_nxt_s;

    // The data byte is produced for the next cursor position so mem_wdata can be registered.
    gen_pattern_expand u_pattern_expand (
        .color    (color_r),
        .byte_idx (byte_nxt_s),
        .wdata    (wdata_nxt_s)
    );

    // Next-state and write-cursor advance logic.
    always_comb begin
        start_s     = gen_start_strobe & ~strobe_d_r;
        accept_s    = mem_we & mem_ready;
        last_byte_s = (byte_idx_r == LAST_BYTE_IDX);
        last_grp_s  = (grp_r == (width_r - 16'd1));
        last_row_s  = (row_r == (height_r - 16'd1));
        state_nxt_s = state_r;
        base_nxt_s  = row_base_r;
        grp_nxt_s   = grp_r;
        row_nxt_s   = row_r;
        addr_nxt_s  = mem_addr;
        byte_nxt_s  = byte_idx_r;

        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                grp_nxt_s  = 16'd0;
                row_nxt_s  = 16'd0;
                byte_nxt_s = 2'd0;
                addr_nxt_s = row_base_r;
                if ((width_r != 16'd0) && (height_r != 16'd0)) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_WRITE;
                end else if (last_byte_s && last_grp_s && last_row_s) begin
                    state_nxt_s = ST_DONE;
                end else if (!last_byte_s) begin
                    byte_nxt_s = byte_idx_r + 2'd1;
                    addr_nxt_s = mem_addr + 16'd1;
                end else if (!last_grp_s) begin
                    // Groups within a row are contiguous, so the address just steps on.
                    byte_nxt_s = 2'd0;
                    grp_nxt_s  = grp_r + 16'd1;
                    addr_nxt_s = mem_addr + 16'd1;
                end else begin
                    byte_nxt_s = 2'd0;
                    grp_nxt_s  = 16'd0;
                    row_nxt_s  = row_r + 16'd1;
                    base_nxt_s = row_base_r + STRIDE_STEP;
                    addr_nxt_s = row_base_r + STRIDE_STEP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, cursor and registered output update.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_r         <= ST_IDLE;
            strobe_d_r      <= 1'b0;
            mem_we          <= 1'b0;
            gen_busy        <= 1'b0;
            gen_done_strobe <= 1'b0;
            mem_addr        <= 16'h0000;
            mem_wdata       <= 8'h00;
            grp_r           <= 16'd0;
            row_r           <= 16'd0;
            byte_idx_r      <= 2'd0;
        end else begin
            state_r         <= state_nxt_s;
            strobe_d_r      <= gen_start_strobe;
            mem_we          <= (state_nxt_s == ST_WRITE);
            gen_busy        <= (state_nxt_s != ST_IDLE);
            gen_done_strobe <= (state_nxt_s == ST_DONE);
            mem_addr        <= addr_nxt_s;
            mem_wdata       <= wdata_nxt_s;
            grp_r           <= grp_nxt_s;
            row_r           <= row_nxt_s;
            byte_idx_r      <= byte_nxt_s;
        end
    end

    // Command capture on a start event; the row base then tracks the cursor.
    always_ff @(posedge clk) begin
        if (rst_) begin
            width_r    <= 16'd0;
            height_r   <= 16'd0;
            color_r    <= 3'd0;
            row_base_r <= 16'h0000;
        end else if ((state_r == ST_IDLE) && start_s) begin
            width_r    <= cmd_data_width;
            height_r   <= cmd_data_height;
            color_r    <= cmd_data_color;
            row_base_r <= init_addr;
        end else begin
            row_base_r <= base_nxt_s;
        end
    end

`ifdef GEN_WR_COUNT_EN
    // Accepted-write counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst_) begin
            gen_wr_count <= 32'd0;
        end else if (accept_s) begin
            gen_wr_count <= gen_wr_count + 32'd1;
        end else begin
            gen_wr_count <= gen_wr_count;
        end
    end
`endif

endmodule
